// File: rtl/operand_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module  : operand_issue_pkg
// Purpose : Shared definitions for the operand-issue stage: instruction field
//           layout, the ALU op type and the ALU op constants.
// Revision: 1.0 - initial release
// ============================================================================
package operand_issue_pkg;

    // Instruction word layout: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt
    localparam int INSTR_W = 16;
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 4;
    localparam int RT_MSB  = 3;
    localparam int RT_LSB  = 0;

    typedef logic [3:0] alu_op_t;
    typedef logic [3:0] reg_idx_t;

    // ALU op constants shared with the ALU. Any other encoding is passed
    // through untouched and treated as a binary op.
    localparam alu_op_t ALU_ADD = 4'h0;
    localparam alu_op_t ALU_SUB = 4'h1;
    localparam alu_op_t ALU_MUL = 4'h2;
    localparam alu_op_t ALU_NEG = 4'h3;

    // Field order matches the bit layout above, so a plain cast decodes.
    typedef struct packed {
        alu_op_t  op;
        reg_idx_t rd;
        reg_idx_t rs;
        reg_idx_t rt;
    } instr_t;

    function automatic logic op_uses_rt(input alu_op_t op);
        return (op != ALU_NEG);
    endfunction

endpackage : operand_issue_pkg
`default_nettype wire

// File: rtl/operand_issue_regfile.sv
`default_nettype none
// ============================================================================
// Module  : operand_issue_regfile
// Purpose : NREG x WIDTH register file, two asynchronous read ports and one
//           synchronous write port. Register 0 is hardwired to zero.
// Ports   : clk, resetn       - clock, asynchronous active-low reset
//           we/waddr/wdata    - write port, takes effect on rising clk
//           raddr_a/rdata_a   - read port A (combinational)
//           raddr_b/rdata_b   - read port B (combinational)
// Revision: 1.0 - initial release
// ============================================================================
module operand_issue_regfile #(
    parameter int WIDTH = 16,
    parameter int NREG  = 16,
    parameter int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem_q [NREG];
    logic [WIDTH-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        // Writes to register 0 are dropped so it always reads zero.
        if (we && (waddr != '0)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule : operand_issue_regfile
`default_nettype wire

// File: rtl/operand_issue.sv
`default_nettype none
// ============================================================================
// Module  : operand_issue
// Purpose : Operand read and issue stage. Decodes an instruction, reads its
//           source registers, tracks outstanding destinations in a one-bit-
//           per-register scoreboard and issues the op to registered ALU
//           inputs once no hazard remains.
// Ports   : clk, resetn               - clock, asynchronous active-low reset
//           instr, instr_valid        - instruction offered by upstream
//           instr_ready               - combinational accept (no hazard)
//           wb_en, wb_addr, wb_data   - write-back from downstream
//           alu_ctrl/a/b/dst/valid    - registered issue outputs
// Config  : OPERAND_ISSUE_FORWARD_EN - when defined, a same-cycle write-back
//           to a pending source is forwarded to the operand and clears that
//           source hazard (no stall). Undefined: stall one cycle instead.
// Revision: 1.0 - initial release
// ============================================================================
module operand_issue
    import operand_issue_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREG  = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             wb_en,
    input  logic [3:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_dst,
    output logic             alu_valid
);

    instr_t           dec;
    logic             use_rt;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic             fwd_rs;
    logic             fwd_rt;
    logic             haz_rs;
    logic             haz_rt;
    logic             haz_rd;
    logic             transfer;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;

    logic [NREG-1:0]  pend_q;
    logic [NREG-1:0]  pend_d;
    logic             alu_valid_q, alu_valid_d;
    logic [3:0]       alu_ctrl_q,  alu_ctrl_d;
    logic [WIDTH-1:0] alu_a_q,     alu_a_d;
    logic [WIDTH-1:0] alu_b_q,     alu_b_d;
    logic [3:0]       alu_dst_q,   alu_dst_d;

    assign dec    = instr_t'(instr);
    assign use_rt = op_uses_rt(dec.op);

    operand_issue_regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_regfile (
        .clk     (clk),
        .resetn  (resetn),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (dec.rs),
        .rdata_a (rdata_a),
        .raddr_b (dec.rt),
        .rdata_b (rdata_b)
    );

`ifdef OPERAND_ISSUE_FORWARD_EN
    // A write landing this edge on a source register supplies the operand
    // directly. Register 0 is excluded because its writes are discarded.
    assign fwd_rs = wb_en && (wb_addr == dec.rs) && (dec.rs != '0);
    assign fwd_rt = wb_en && (wb_addr == dec.rt) && (dec.rt != '0);
`else
    assign fwd_rs = 1'b0;
    assign fwd_rt = 1'b0;
`endif

    // Destination is always checked: a pending rd would let a younger write
    // overtake an older one. Forwarding only relaxes source hazards.
    assign haz_rs      = pend_q[dec.rs] && !fwd_rs;
    assign haz_rt      = use_rt && pend_q[dec.rt] && !fwd_rt;
    assign haz_rd      = pend_q[dec.rd];
    assign instr_ready = !(haz_rs || haz_rt || haz_rd);
    assign transfer    = instr_valid && instr_ready;

    assign opnd_a = fwd_rs ? wb_data : rdata_a;
    assign opnd_b = !use_rt ? '0 : (fwd_rt ? wb_data : rdata_b);

    always_comb begin
        pend_d = pend_q;
        // Clear first, then set, so an issue to the same register wins.
        if (wb_en) begin
            pend_d[wb_addr] = 1'b0;
        end
        if (transfer) begin
            pend_d[dec.rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_comb begin
        alu_valid_d = transfer;
        alu_ctrl_d  = alu_ctrl_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_dst_d   = alu_dst_q;
        if (transfer) begin
            alu_ctrl_d = dec.op;
            alu_a_d    = opnd_a;
            alu_b_d    = opnd_b;
            alu_dst_d  = dec.rd;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q      <= '0;
            alu_valid_q <= 1'b0;
            alu_ctrl_q  <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_dst_q   <= '0;
        end else begin
            pend_q      <= pend_d;
            alu_valid_q <= alu_valid_d;
            alu_ctrl_q  <= alu_ctrl_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_dst_q   <= alu_dst_d;
        end
    end

    assign alu_valid = alu_valid_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_dst   = alu_dst_q;

endmodule : operand_issue
`default_nettype wire

// File: tb/tb_operand_issue.sv
`default_nettype none
// ============================================================================
// Module  : tb_operand_issue
// Purpose : Directed self-checking bench for operand_issue. Expected values
//           are hand-computed; OPERAND_ISSUE_FORWARD_EN selects the expected
//           forwarding behaviour.
// Revision: 1.0 - initial release
// ============================================================================
module tb_operand_issue;
    import operand_issue_pkg::*;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             resetn;
    logic [15:0]      instr;
    logic             instr_valid;
    logic             instr_ready;
    logic             wb_en;
    logic [3:0]       wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_dst;
    logic             alu_valid;

    int n_checks = 0;
    int n_fail   = 0;

    operand_issue #(.WIDTH(WIDTH), .NREG(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .alu_ctrl    (alu_ctrl),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_dst     (alu_dst),
        .alu_valid   (alu_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [3:0] rt);
        return {op, rd, rs, rt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_issue(input string tag, input logic [3:0] ctrl,
                               input logic [15:0] a, input logic [15:0] b, input logic [3:0] dst);
        check_eq({tag, "_valid"}, {31'd0, alu_valid}, 32'd1);
        check_eq({tag, "_ctrl"},  {28'd0, alu_ctrl},  {28'd0, ctrl});
        check_eq({tag, "_a"},     {16'd0, alu_a},     {16'd0, a});
        check_eq({tag, "_b"},     {16'd0, alu_b},     {16'd0, b});
        check_eq({tag, "_dst"},   {28'd0, alu_dst},   {28'd0, dst});
    endtask

    initial begin
        // Reset with an instruction and a write-back offered: both discarded.
        resetn      = 1'b0;
        instr       = mk(ALU_ADD, 4'd1, 4'd2, 4'd3);
        instr_valid = 1'b1;
        wb_en       = 1'b1;
        wb_addr     = 4'd1;
        wb_data     = 16'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", {31'd0, alu_valid}, 32'd0);
        check_eq("rst_ctrl",  {28'd0, alu_ctrl},  32'd0);
        check_eq("rst_a",     {16'd0, alu_a},     32'd0);
        check_eq("rst_b",     {16'd0, alu_b},     32'd0);
        check_eq("rst_dst",   {28'd0, alu_dst},   32'd0);
        check_eq("rst_ready", {31'd0, instr_ready}, 32'd1);

        resetn      = 1'b1;
        instr_valid = 1'b0;
        wb_en       = 1'b0;
        tick();
        check_eq("post_rst_valid", {31'd0, alu_valid}, 32'd0);

        // Basic issue: R1=0x00F0, R2=0x000F, ADD r3,r1,r2
        wb_en = 1'b1; wb_addr = 4'd1; wb_data = 16'h00F0;
        tick();
        wb_addr = 4'd2; wb_data = 16'h000F;
        tick();
        wb_en = 1'b0;
        instr = mk(ALU_ADD, 4'd3, 4'd1, 4'd2); instr_valid = 1'b1;
        settle();
        check_eq("add_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        instr_valid = 1'b0;
        check_issue("add", ALU_ADD, 16'h00F0, 16'h000F, 4'd3);
        tick();
        check_eq("idle_valid", {31'd0, alu_valid}, 32'd0);
        check_eq("idle_hold_a", {16'd0, alu_a}, 32'h00F0);

        // RAW stall on r3 until its write-back
        instr = mk(ALU_SUB, 4'd4, 4'd3, 4'd1); instr_valid = 1'b1;
        settle();
        check_eq("raw_ready0", {31'd0, instr_ready}, 32'd0);
        tick();
        check_eq("raw_stall_valid", {31'd0, alu_valid}, 32'd0);
        check_eq("raw_hold_ctrl", {28'd0, alu_ctrl}, {28'd0, ALU_ADD});
        wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'h0ABC;
        settle();
`ifdef OPERAND_ISSUE_FORWARD_EN
        check_eq("raw_fwd_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        wb_en = 1'b0; instr_valid = 1'b0;
`else
        check_eq("raw_wb_ready", {31'd0, instr_ready}, 32'd0);
        tick();
        wb_en = 1'b0;
        check_eq("raw_wb_valid", {31'd0, alu_valid}, 32'd0);
        settle();
        check_eq("raw_after_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        instr_valid = 1'b0;
`endif
        check_issue("raw_sub", ALU_SUB, 16'h0ABC, 16'h00F0, 4'd4);

        // NEG ignores a pending rt and forces operand B to zero
        instr = mk(ALU_MUL, 4'd3, 4'd1, 4'd2); instr_valid = 1'b1;
        settle();
        check_eq("mul_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        check_issue("mul", ALU_MUL, 16'h00F0, 16'h000F, 4'd3);
        instr = mk(ALU_NEG, 4'd5, 4'd1, 4'd3);
        settle();
        check_eq("neg_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        check_issue("neg", ALU_NEG, 16'h00F0, 16'h0000, 4'd5);
        instr = mk(ALU_NEG, 4'd7, 4'd3, 4'd0);
        settle();
        check_eq("neg_rs_pend_ready", {31'd0, instr_ready}, 32'd0);
        instr_valid = 1'b0;

        // Same-cycle write-back to pending source r3
        instr = mk(ALU_SUB, 4'd6, 4'd3, 4'd1); instr_valid = 1'b1;
        wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'h0100;
        settle();
`ifdef OPERAND_ISSUE_FORWARD_EN
        check_eq("fwd_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        wb_en = 1'b0; instr_valid = 1'b0;
`else
        check_eq("nofwd_ready", {31'd0, instr_ready}, 32'd0);
        tick();
        wb_en = 1'b0;
        check_eq("nofwd_stall_valid", {31'd0, alu_valid}, 32'd0);
        settle();
        check_eq("nofwd_after_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        instr_valid = 1'b0;
`endif
        check_issue("wbsame_sub", ALU_SUB, 16'h0100, 16'h00F0, 4'd6);

        // WAW: r4 still pending from the earlier SUB
        instr = mk(ALU_ADD, 4'd4, 4'd1, 4'd2); instr_valid = 1'b1;
        settle();
        check_eq("waw_ready0", {31'd0, instr_ready}, 32'd0);
        tick();
        check_eq("waw_stall_valid", {31'd0, alu_valid}, 32'd0);
        wb_en = 1'b1; wb_addr = 4'd4; wb_data = 16'h5555;
        tick();
        wb_en = 1'b0;
        settle();
        check_eq("waw_ready1", {31'd0, instr_ready}, 32'd1);
        tick();
        instr_valid = 1'b0;
        check_issue("waw_add", ALU_ADD, 16'h00F0, 16'h000F, 4'd4);

        // Set and clear of r7 in the same cycle: r7 must end up pending
        instr = mk(ALU_ADD, 4'd7, 4'd1, 4'd2); instr_valid = 1'b1;
        wb_en = 1'b1; wb_addr = 4'd7; wb_data = 16'h7777;
        settle();
        check_eq("setwin_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        wb_en = 1'b0;
        check_issue("setwin_add", ALU_ADD, 16'h00F0, 16'h000F, 4'd7);
        instr = mk(ALU_ADD, 4'd8, 4'd7, 4'd1);
        settle();
        check_eq("setwin_pending", {31'd0, instr_ready}, 32'd0);
        instr_valid = 1'b0;

        // Register 0: writes ignored, reads zero, never pending
        wb_en = 1'b1; wb_addr = 4'd0; wb_data = 16'hFFFF;
        tick();
        wb_en = 1'b0;
        instr = mk(ALU_ADD, 4'd1, 4'd0, 4'd0); instr_valid = 1'b1;
        settle();
        check_eq("r0_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        instr_valid = 1'b0;
        check_issue("r0_add", ALU_ADD, 16'h0000, 16'h0000, 4'd1);

        // Asynchronous reset in the middle of a stall on r3
        instr = mk(ALU_ADD, 4'd3, 4'd2, 4'd2); instr_valid = 1'b1;
        settle();
        check_eq("pre_rst_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        check_issue("pre_rst_add", ALU_ADD, 16'h000F, 16'h000F, 4'd3);
        instr = mk(ALU_SUB, 4'd9, 4'd3, 4'd2);
        settle();
        check_eq("mid_stall_ready", {31'd0, instr_ready}, 32'd0);
        tick();
        check_eq("mid_stall_valid", {31'd0, alu_valid}, 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("async_rst_valid", {31'd0, alu_valid}, 32'd0);
        check_eq("async_rst_ctrl",  {28'd0, alu_ctrl},  32'd0);
        check_eq("async_rst_a",     {16'd0, alu_a},     32'd0);
        check_eq("async_rst_b",     {16'd0, alu_b},     32'd0);
        check_eq("async_rst_dst",   {28'd0, alu_dst},   32'd0);
        check_eq("async_rst_ready", {31'd0, instr_ready}, 32'd1);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        instr  = mk(ALU_ADD, 4'd6, 4'd3, 4'd3); instr_valid = 1'b1;
        settle();
        check_eq("post_rst2_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        instr_valid = 1'b0;
        check_issue("post_rst2_add", ALU_ADD, 16'h0000, 16'h0000, 4'd6);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_operand_issue
`default_nettype wire

// File: doc/operand_issue.md
OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 Parameter WIDTH, 16, datapath width of registers and ALU operands.
REQ-002 Parameter NREG, 16, register count; register index width is log2(NREG) = 4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 instr  input  16  instruction word: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt.
REQ-006 instr_valid  input  1  instr holds a valid instruction.
REQ-007 instr_ready  output  1  block accepts instr this cycle.
REQ-008 wb_en  input  1  write-back strobe from the downstream stage.
REQ-009 wb_addr  input  4  write-back destination register.
REQ-010 wb_data  input  WIDTH  write-back value.
REQ-011 alu_ctrl  output  4  registered ALU operation; drives the ALU ctrl port.
REQ-012 alu_a  output  WIDTH  registered operand A; drives the ALU a port.
REQ-013 alu_b  output  WIDTH  registered operand B; drives the ALU b port.
REQ-014 alu_dst  output  4  registered destination index of the issued op.
REQ-015 alu_valid  output  1  issue registers hold a newly issued op.

Function
REQ-016 Transfer occurs on a rising edge with instr_valid && instr_ready.
REQ-017 On transfer, alu_ctrl=op, alu_dst=rd, alu_a=R[rs], alu_b=R[rt]; alu_valid=1 for exactly the following cycle.
REQ-018 No transfer: alu_valid=0; alu_ctrl/alu_a/alu_b/alu_dst hold their previous values.
REQ-019 op encodings are the shared ALU op constants (ADD, SUB, MUL, NEG); op passes through unchanged.
REQ-020 NEG is unary: alu_b=0; rt is ignored for hazard checks.
REQ-021 Register 0 reads 0, ignores writes and is never pending.
REQ-022 Scoreboard: one pending bit per register; set for rd on transfer (rd != 0); cleared by wb_en at wb_addr.
REQ-023 Set and clear on the same register in the same cycle: set wins.
REQ-024 Hazard when a used source (rs; rt unless NEG) or rd is pending; instr_ready = !hazard, combinational, one cycle of lookup only.
REQ-025 Hazard check includes rd, preventing write-after-write reordering.
REQ-026 A register write by wb_en takes effect at the rising edge; the write data is readable on the next cycle.
REQ-027 instr_ready is independent of instr_valid; an unaccepted instr is held stable by the upstream stage.

Reset
REQ-028 resetn low asynchronously clears all registers, the scoreboard, alu_valid, alu_ctrl, alu_a, alu_b and alu_dst to 0.
REQ-029 An instruction offered while resetn is low is discarded; the first transfer is possible on the first edge with resetn high.

Configuration
REQ-030 Macro OPERAND_ISSUE_FORWARD_EN defined: a same-cycle wb_en write to a pending source register forwards wb_data to the operand and clears that hazard in the same cycle (zero-stall).
REQ-031 Macro absent: the same situation stalls one cycle; instr issues on the following edge with the register-file value.

Structure
REQ-032 Instruction field positions, the op typedef and the ALU op constants live in the shared parameters package.
REQ-033 Register storage is a sub-module, regfile: two read ports, one write port, asynchronous reset.

Verification
REQ-034 Write R1=0x00F0 and R2=0x000F, then ADD r3,r1,r2 -> next cycle alu_valid=1, alu_a=0x00F0, alu_b=0x000F, alu_dst=3.
REQ-035 Issue ADD r3,r1,r2, then SUB r4,r3,r1 with no write-back -> instr_ready=0 until wb_en for addr 3; SUB then issues with alu_a equal to the written value.
REQ-036 NEG r5,r1,r3 with r3 pending -> issues with no stall, alu_b=0.
REQ-037 wb_en addr 3 data 0x0100 in the same cycle as SUB r4,r3,r1 is offered -> with FORWARD_EN, issues that edge with alu_a=0x0100; without FORWARD_EN, issues one edge later.
REQ-038 Drop resetn mid-stall with r3 pending -> outputs are 0 at once; after release, ADD r6,r3,r3 issues immediately with operands 0.
REQ-039 Write to r0 with 0xFFFF, then ADD r1,r0,r0 -> alu_a=alu_b=0 and no stall.
